timer_mag: RTL and testbench

// - Cook-time countdown stage directly upstream of the magnetron control logic. It produces the

---
 rtl/timer_mag.sv | 180 ++++++++++++++++++
 tb/tb_timer_mag.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mag.sv
// timer_mag: MM:SS cook-time countdown feeding the magnetron control stage.
// Digits are entered as BCD from the keypad by shifting left. The timer counts
// down once per CLK_HZ cycles while mag_on is high, and it raises timer_done
// at 00:00.
// Optional feature: define DONE_BEEP_EN to get a completion beeper. The beeper
// stays high for BEEP_SECS seconds, timed off the same prescaler. Without the
// macro, the beep port is tied low and BEEP_SECS does not exist.
module timer_mag #(
`ifdef DONE_BEEP_EN
    parameter int BEEP_SECS = 3,
`endif
    parameter int CLK_HZ    = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       clearn,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       beep
);

    localparam int            PW      = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_mt, r_mo, r_st, r_so;
    logic [PW-1:0] r_pre;
    logic          r_done;

    logic       w_key_ok;
    logic       w_zero;
    logic       w_tick;
    logic       w_run;
    logic       w_b0, w_b1, w_b2;
    logic [3:0] w_mt_dec, w_mo_dec, w_st_dec, w_so_dec;
    logic       w_dec_zero;

    assign w_key_ok = key_valid && (key_digit <= 4'd9);
    assign w_zero   = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
    assign w_tick   = (r_pre == PRE_MAX);

    // Counting happens in COUNT, and also on the very edge that moves ENTRY
    // into COUNT. A resumed count therefore continues from the held
    // prescaler value, with no dead cycle.
    assign w_run = mag_on && !w_zero && ((r_state == ENTRY) || (r_state == COUNT));

    // Ripple-borrow BCD decrement. Seconds tens wraps to 5. A sec_tens value
    // above 5 that was keyed in just counts down through the digits.
    assign w_b0     = (r_so == 4'd0);
    assign w_b1     = w_b0 && (r_st == 4'd0);
    assign w_b2     = w_b1 && (r_mo == 4'd0);
    assign w_so_dec = w_b0 ? 4'd9 : (r_so - 4'd1);
    assign w_st_dec = !w_b0 ? r_st : ((r_st == 4'd0) ? 4'd5 : (r_st - 4'd1));
    assign w_mo_dec = !w_b1 ? r_mo : ((r_mo == 4'd0) ? 4'd9 : (r_mo - 4'd1));
    assign w_mt_dec = !w_b2 ? r_mt : (r_mt - 4'd1);
    assign w_dec_zero = (w_mt_dec == 4'd0) && (w_mo_dec == 4'd0) &&
                        (w_st_dec == 4'd0) && (w_so_dec == 4'd0);

`ifdef DONE_BEEP_EN
    localparam int            BW        = $clog2(BEEP_SECS + 1);
    localparam logic [BW-1:0] BSEC_LAST = BW'(BEEP_SECS - 1);

    logic          r_beep;
    logic [BW-1:0] r_bsec;
    logic          w_enter_done;

    // Same two paths into DONE as in the state machine below.
    assign w_enter_done = (w_run && w_tick && w_dec_zero) ||
                          ((r_state == ENTRY) && mag_on && w_zero);
`endif

    // Main timer state machine: digit entry, prescaler, countdown and DONE handling.
    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            r_state <= ENTRY;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else if (w_run) begin
            if (w_tick) begin
                r_mt  <= w_mt_dec;
                r_mo  <= w_mo_dec;
                r_st  <= w_st_dec;
                r_so  <= w_so_dec;
                r_pre <= '0;
                if (w_dec_zero) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= COUNT;
                end
            end else begin
                r_pre   <= r_pre + PW'(1);
                r_state <= COUNT;
            end
        end else begin
            case (r_state)
                ENTRY: begin
                    // mag_on with nonzero digits is handled by w_run, so
                    // mag_on here always means an empty timer.
                    if (mag_on) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pre   <= '0;
                    end else if (w_key_ok) begin
                        r_mt <= r_mo;
                        r_mo <= r_st;
                        r_st <= r_so;
                        r_so <= key_digit;
                    end
                end
                COUNT: begin
                    // mag_on dropped: hold digits and prescaler, then allow editing.
                    r_state <= ENTRY;
                end
                DONE: begin
                    if (w_key_ok) begin
                        r_state <= ENTRY;
                        r_done  <= 1'b0;
                        r_mt    <= 4'd0;
                        r_mo    <= 4'd0;
                        r_st    <= 4'd0;
                        r_so    <= key_digit;
                        r_pre   <= '0;
                    end
`ifdef DONE_BEEP_EN
                    else if (r_beep) begin
                        r_pre <= w_tick ? '0 : (r_pre + PW'(1));
                    end
`endif
                end
                default: r_state <= ENTRY;
            endcase
        end
    end

`ifdef DONE_BEEP_EN
    // Beeper: starts on DONE entry, counts prescaler ticks, ends early on clear or key.
    always_ff @(posedge clk) begin
        if (rst || !clearn) begin
            r_beep <= 1'b0;
            r_bsec <= '0;
        end else if (w_enter_done) begin
            r_beep <= 1'b1;
            r_bsec <= '0;
        end else if ((r_state == DONE) && w_key_ok) begin
            r_beep <= 1'b0;
        end else if ((r_state == DONE) && r_beep && w_tick) begin
            r_bsec <= r_bsec + BW'(1);
            if (r_bsec == BSEC_LAST) r_beep <= 1'b0;
        end
    end

    assign beep = r_beep;
`else
    assign beep = 1'b0;
`endif

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign timer_done = r_done;

endmodule

// File: tb/tb_timer_mag.sv
// Bench for timer_mag with CLK_HZ=4. Each scenario task pushes the expected
// display, done and beep values into a scoreboard as it drives each cycle.
// It then pops and checks those values once that cycle's edge has been taken.
module tb_timer_mag;

    logic       clk = 1'b0;
    logic       rst, key_valid, clearn, mag_on;
    logic [3:0] key_digit;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, beep;
    logic [15:0] obs;

`ifdef DONE_BEEP_EN
    localparam bit BP = 1'b1;
    timer_mag #(.BEEP_SECS(3), .CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
        .clearn(clearn), .mag_on(mag_on),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .beep(beep));
`else
    localparam bit BP = 1'b0;
    timer_mag #(.CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
        .clearn(clearn), .mag_on(mag_on),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .beep(beep));
`endif

    always #5 clk = ~clk;
    assign obs = {min_tens, min_ones, sec_tens, sec_ones};

    typedef struct {
        bit          kv;
        logic [3:0]  kd;
        bit          mg;
        bit          cl;
        logic [15:0] d;
        logic        dn;
        logic        bp;
    } step_t;

    typedef struct {
        string       name;
        logic [15:0] d;
        logic        dn;
        logic        bp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic step_t mk(bit kv, logic [3:0] kd, bit mg, bit cl,
                                 logic [15:0] d, logic dn, logic bp);
        step_t s;
        s.kv = kv; s.kd = kd; s.mg = mg; s.cl = cl; s.d = d; s.dn = dn; s.bp = bp;
        return s;
    endfunction

    // Reference BCD decrement, done digit by digit with per-position wrap values.
    function automatic logic [15:0] bdec(input logic [15:0] v);
        logic [15:0] r;
        bit          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] dg;
            dg = r[i*4 +: 4];
            if (borrow) begin
                if (dg == 4'd0) dg = (i == 1) ? 4'd5 : 4'd9;
                else begin
                    dg     = dg - 4'd1;
                    borrow = 1'b0;
                end
                r[i*4 +: 4] = dg;
            end
        end
        return r;
    endfunction

    // Apply one cycle of inputs, record what must be visible after the edge, then take the edge.
    task automatic drive(input step_t s, input string nm);
        exp_t e;
        key_valid = s.kv;
        key_digit = s.kd;
        mag_on    = s.mg;
        clearn    = s.cl;
        e.name = nm; e.d = s.d; e.dn = s.dn; e.bp = s.bp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(mk(1, 4'd5, 0, 1, 16'h0000, 0, 0), "reset");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_keys();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 4'd1,  0, 1, 16'h0001, 0, 0));
        s.push_back(mk(1, 4'd3,  0, 1, 16'h0013, 0, 0));
        s.push_back(mk(1, 4'd0,  0, 1, 16'h0130, 0, 0));
        s.push_back(mk(0, 4'd0,  0, 1, 16'h0130, 0, 0));
        s.push_back(mk(1, 4'd9,  0, 1, 16'h1309, 0, 0));
        s.push_back(mk(1, 4'd2,  0, 1, 16'h3092, 0, 0));
        s.push_back(mk(1, 4'd12, 0, 1, 16'h3092, 0, 0));
        s.push_back(mk(1, 4'd5,  1, 1, 16'h3092, 0, 0));
        s.push_back(mk(0, 4'd0,  0, 1, 16'h3092, 0, 0));
        s.push_back(mk(0, 4'd0,  0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "keys");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    // 01:00 all the way to DONE, then remain in DONE with mag_on still high.
    task automatic test_countdown();
        step_t       s[$];
        exp_t        e;
        logic [15:0] m;
        bit          mdone;
        int          dc;
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd1, 0, 1, 16'h0001, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h0010, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h0100, 0, 0));
        m = 16'h0100; mdone = 1'b0; dc = 0;
        for (int c = 0; c < 256; c++) begin
            if (!mdone && (c % 4) == 3) begin
                m = bdec(m);
                if (m == 16'h0000) begin
                    mdone = 1'b1;
                    dc    = c;
                end
            end
            s.push_back(mk(0, 4'd0, 1, 1, m, mdone, BP && mdone && (c - dc) < 12));
        end
        foreach (s[i]) begin
            drive(s[i], "countdown");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    task automatic test_done_key();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd1, 0, 1, 16'h0001, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0001, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0001, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0001, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0000, 1, BP));
        s.push_back(mk(1, 4'd7, 0, 1, 16'h0007, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0007, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "done_key");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    task automatic test_pause();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd5, 0, 1, 16'h0005, 0, 0));
        for (int c = 0; c < 6; c++)
            s.push_back(mk(0, 4'd0, 1, 1, (c >= 3) ? 16'h0004 : 16'h0005, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0004, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0004, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0004, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0003, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "pause");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    task automatic test_zero_start();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 4'd0,  0, 0, 16'h0000, 0, 0));
        s.push_back(mk(0, 4'd0,  1, 1, 16'h0000, 1, BP));
        s.push_back(mk(0, 4'd0,  0, 1, 16'h0000, 1, BP));
        s.push_back(mk(1, 4'd12, 0, 1, 16'h0000, 1, BP));
        s.push_back(mk(0, 4'd0,  0, 0, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "zero_start");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    task automatic test_clear_tick();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd2, 0, 1, 16'h0002, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0002, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0002, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 1, 16'h0002, 0, 0));
        s.push_back(mk(0, 4'd0, 1, 0, 16'h0000, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0000, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "clear_tick");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    // Full borrow chain 10:00 -> 09:59, and the 00:90 entry.
    // In the 00:90 case, mag_on falls right after a tick edge.
    task automatic test_borrow();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd1, 0, 1, 16'h0001, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h0010, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h0100, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h1000, 0, 0));
        for (int c = 0; c < 4; c++)
            s.push_back(mk(0, 4'd0, 1, 1, (c == 3) ? 16'h0959 : 16'h1000, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 0, 16'h0000, 0, 0));
        s.push_back(mk(1, 4'd9, 0, 1, 16'h0009, 0, 0));
        s.push_back(mk(1, 4'd0, 0, 1, 16'h0090, 0, 0));
        for (int c = 0; c < 4; c++)
            s.push_back(mk(0, 4'd0, 1, 1, (c == 3) ? 16'h0089 : 16'h0090, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0089, 0, 0));
        s.push_back(mk(0, 4'd0, 0, 1, 16'h0089, 0, 0));
        foreach (s[i]) begin
            drive(s[i], "borrow");
            e = sb.pop_front();
            checks++;
            if (obs !== e.d || timer_done !== e.dn || beep !== e.bp) begin
                errors++;
                $display("FAIL %s[%0d]: got %h done=%b beep=%b, expected %h done=%b beep=%b",
                         e.name, i, obs, timer_done, beep, e.d, e.dn, e.bp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        clearn    = 1'b1;
        mag_on    = 1'b0;
        test_reset();
        test_keys();
        test_countdown();
        test_done_key();
        test_pause();
        test_zero_start();
        test_clear_tick();
        test_borrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
